// File: rtl/collision_scanner.sv
// collision_scanner: per-frame walk of the object table producing one side-of-contact code per slot.
// Optional macro HIT_COUNT_EN adds an 8-bit saturating hit_count output.
module collision_scanner #(
    parameter int N_OBJ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      player_coord,
    input  logic [31:0]      player_size,
    output logic [IDX_W-1:0] obj_sel,
    input  logic [31:0]      obj_coord,
    input  logic [31:0]      obj_size,
    input  logic             obj_enable,
    output logic             coll_valid,
    output logic [IDX_W-1:0] coll_idx,
    output logic [3:0]       coll_dir,
    output logic             busy,
`ifdef HIT_COUNT_EN
    output logic             done,
    output logic [7:0]       hit_count
`else
    output logic             done
`endif
);
    typedef enum logic [2:0] {IDLE, ADDR, CALC, EMIT, DONE} state_t;
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      p_coord, p_size;
    logic [16:0]      p_r, p_b, o_r, o_b;
    logic signed [17:0] ovx, ovy;
    logic             hit;
    logic [3:0]       dir;
    // Right/bottom edges are 17 bits so boxes at the top of the coordinate range never wrap.
    assign p_r = {1'b0, p_coord[31:16]} + {1'b0, p_size[31:16]};
    assign p_b = {1'b0, p_coord[15:0]} + {1'b0, p_size[15:0]};
    assign o_r = {1'b0, obj_coord[31:16]} + {1'b0, obj_size[31:16]};
    assign o_b = {1'b0, obj_coord[15:0]} + {1'b0, obj_size[15:0]};
    assign ovx = $signed({1'b0, (p_r < o_r ? p_r : o_r)})
               - $signed({2'b0, (p_coord[31:16] > obj_coord[31:16] ? p_coord[31:16] : obj_coord[31:16])});
    assign ovy = $signed({1'b0, (p_b < o_b ? p_b : o_b)})
               - $signed({2'b0, (p_coord[15:0] > obj_coord[15:0] ? p_coord[15:0] : obj_coord[15:0])});
    // A zero-size player yields non-positive overlap, so it needs no separate test.
    assign hit = ovx > 18'sd0 && ovy > 18'sd0 && obj_enable && obj_size[31:16] != 16'd0
              && obj_size[15:0] != 16'd0 && obj_coord != 32'hFFFF_FFFF;
    // Smaller overlap axis picks the contact side; ties resolve vertically.
    assign dir = !hit ? 4'b0000
               : ovx < ovy ? (p_coord[31:16] < obj_coord[31:16] ? 4'b0100 : 4'b1000)
               : (p_coord[15:0] < obj_coord[15:0] ? 4'b0001 : 4'b0010);

    // Scan sequencer: three cycles per slot, then a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            obj_sel    <= '0;
            coll_valid <= 1'b0;
            coll_idx   <= '0;
            coll_dir   <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            p_coord    <= '0;
            p_size     <= '0;
`ifdef HIT_COUNT_EN
            hit_count  <= 8'd0;
`endif
        end else begin
            coll_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    p_coord   <= player_coord;
                    p_size    <= player_size;
                    busy      <= 1'b1;
                    idx       <= '0;
                    obj_sel   <= '0;
                    state     <= ADDR;
`ifdef HIT_COUNT_EN
                    hit_count <= 8'd0;
`endif
                end
                ADDR: state <= CALC;
                CALC: begin
                    coll_valid <= 1'b1;
                    coll_idx   <= idx;
                    coll_dir   <= dir;
                    state      <= EMIT;
`ifdef HIT_COUNT_EN
                    if (dir != 4'b0000 && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
`endif
                end
                EMIT: if (idx == IDX_W'(N_OBJ - 1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    idx     <= idx + 1'b1;
                    obj_sel <= idx + 1'b1;
                    state   <= ADDR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: randomized and directed checks of collision_scanner against a phase-based reference model.
module tb_collision_scanner;
    localparam int N = 4;
    localparam int IW = 2;
    logic clk = 0, rst = 1, start = 0, obj_enable;
    logic [31:0] player_coord = 0, player_size = 0, obj_coord, obj_size;
    logic [IW-1:0] obj_sel, coll_idx;
    logic coll_valid, busy, done;
    logic [3:0] coll_dir;
    logic [31:0] tbl_c [N];
    logic [31:0] tbl_s [N];
    logic        tbl_e [N];
    logic [3:0]  exp_dir [N];
    logic [3:0]  cap_dir [N];
    int checks = 0, errors = 0, cyc = 0, ph = -1, hc = 0;
`ifdef HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    collision_scanner #(.N_OBJ(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .player_coord(player_coord), .player_size(player_size),
        .obj_sel(obj_sel), .obj_coord(obj_coord), .obj_size(obj_size), .obj_enable(obj_enable),
        .coll_valid(coll_valid), .coll_idx(coll_idx), .coll_dir(coll_dir), .busy(busy),
`ifdef HIT_COUNT_EN
        .done(done), .hit_count(hit_count)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    // Object table with one cycle of read latency.
    always @(posedge clk) begin
        obj_coord  <= tbl_c[obj_sel];
        obj_size   <= tbl_s[obj_sel];
        obj_enable <= tbl_e[obj_sel];
    end

    function automatic logic [3:0] ref_dir(logic [31:0] pc, logic [31:0] ps, logic [31:0] oc, logic [31:0] os, logic en);
        int px, py, ox, oy, ow, oh, ovx, ovy;
        px = pc[31:16]; py = pc[15:0]; ox = oc[31:16]; oy = oc[15:0];
        ow = os[31:16]; oh = os[15:0];
        ovx = ((px + int'(ps[31:16])) < (ox + ow) ? px + int'(ps[31:16]) : ox + ow) - (px > ox ? px : ox);
        ovy = ((py + int'(ps[15:0])) < (oy + oh) ? py + int'(ps[15:0]) : oy + oh) - (py > oy ? py : oy);
        if (!(ovx > 0 && ovy > 0 && en && ow != 0 && oh != 0 && oc != 32'hFFFF_FFFF)) return 4'b0000;
        if (ovx < ovy) return px < ox ? 4'b0100 : 4'b1000;
        return py < oy ? 4'b0001 : 4'b0010;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: ph counts cycles since the accepted start; -1 when idle.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            ph = -1;
            hc = 0;
        end else if (ph == -1) begin
            if (start) begin
                ph = 1;
                hc = 0;
                for (int i = 0; i < N; i++) exp_dir[i] = ref_dir(player_coord, player_size, tbl_c[i], tbl_s[i], tbl_e[i]);
            end
        end else begin
            ph = (ph == 3 * N + 1) ? -1 : ph + 1;
            if (ph >= 3 && ph <= 3 * N && ph % 3 == 0 && exp_dir[ph / 3 - 1] != 0 && hc < 255) hc++;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", busy, ph >= 1 && ph <= 3 * N);
            chk("coll_valid", coll_valid, ph >= 3 && ph <= 3 * N && ph % 3 == 0);
            chk("done", done, ph == 3 * N + 1);
            if (ph >= 3 && ph <= 3 * N && ph % 3 == 0) begin
                chk("coll_idx", coll_idx, ph / 3 - 1);
                chk("coll_dir", coll_dir, exp_dir[ph / 3 - 1]);
            end
            if (ph >= 1 && ph <= 3 * N && ph % 3 != 0) chk("obj_sel", obj_sel, ph / 3);
`ifdef HIT_COUNT_EN
            chk("hit_count", hit_count, hc);
`endif
        end
    end

    function automatic logic [31:0] rnd_coord();
        int r = $urandom_range(0, 15);
        if (r == 0) return 32'hFFFF_FFFF;
        if (r == 1) return {16'($urandom_range(16'hFFE0, 16'hFFFF)), 16'($urandom_range(0, 40))};
        return {16'($urandom_range(0, 40)), 16'($urandom_range(0, 40))};
    endfunction

    function automatic logic [31:0] rnd_size();
        return {16'($urandom_range(0, 20)), 16'($urandom_range(0, 20))};
    endfunction

    // Runs one scan from idle; extra start pulses at k==4 and in the done cycle must be ignored.
    task automatic run_scan(output int lat, output int np);
        int k;
        lat = -1; np = 0; k = 0;
        for (int i = 0; i < N; i++) cap_dir[i] = 4'hx;
        start = 1;
        while (k < 40 && lat < 0) begin
            @(negedge clk);
            k++;
            start = (k == 4) || busy && k == 3 * N;
            player_coord = $urandom;
            if (coll_valid) begin
                np++;
                cap_dir[coll_idx] = coll_dir;
            end
            if (done) lat = k;
        end
        start = 0;
        @(negedge clk);
        @(negedge clk);
        if (lat < 0) chk("scan_timeout", 0, 1);
    endtask

    initial begin
        int lat, np;
        chk("model_left", ref_dir({16'd10, 16'd10}, {16'd8, 16'd8}, {16'd14, 16'd12}, {16'd16, 16'd16}, 1), 4'b0100);
        chk("model_top", ref_dir(0, {16'd16, 16'd4}, {16'd2, 16'd3}, {16'd4, 16'd16}, 1), 4'b0001);
        chk("model_tie", ref_dir(0, {16'd8, 16'd8}, {16'd4, 16'd4}, {16'd8, 16'd8}, 1), 4'b0001);
        chk("model_touch", ref_dir(0, {16'd8, 16'd8}, {16'd8, 16'd0}, {16'd8, 16'd8}, 1), 4'b0000);
        chk("model_removed", ref_dir(0, {16'd8, 16'd8}, 32'hFFFF_FFFF, {16'd8, 16'd8}, 1), 4'b0000);
        chk("model_disabled", ref_dir(0, {16'd8, 16'd8}, {16'd4, 16'd0}, {16'd8, 16'd8}, 0), 4'b0000);
        chk("model_wide", ref_dir({16'hFFF0, 16'd0}, {16'd16, 16'd8}, {16'hFFF8, 16'd0}, {16'd8, 16'd8}, 1), 4'b0010);
        for (int i = 0; i < N; i++) begin
            tbl_c[i] = 0; tbl_s[i] = {16'd16, 16'd16}; tbl_e[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", coll_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_dir", coll_dir, 0);
        chk("rst_sel", obj_sel, 0);
        // Basic scan: only slot 2 enabled and overlapping.
        tbl_c[2] = {16'd14, 16'd12}; tbl_e[2] = 1;
        player_coord = {16'd10, 16'd10}; player_size = {16'd8, 16'd8};
        run_scan(lat, np);
        chk("latency", lat, 13);
        chk("pulses", np, 4);
        chk("dir2", cap_dir[2], 4'b0100);
        chk("dir0", cap_dir[0], 4'b0000);
        // Wide coordinates, tie, edge touch, removed marker.
        tbl_c[0] = {16'hFFF8, 16'd0}; tbl_s[0] = {16'd8, 16'd8}; tbl_e[0] = 1;
        tbl_c[1] = {16'hFFF8, 16'd0}; tbl_s[1] = {16'd8, 16'd8}; tbl_e[1] = 0;
        tbl_c[2] = 32'hFFFF_FFFF;     tbl_s[2] = {16'd8, 16'd8}; tbl_e[2] = 1;
        tbl_c[3] = {16'hFFE8, 16'd0}; tbl_s[3] = {16'd8, 16'd8}; tbl_e[3] = 1;
        player_coord = {16'hFFF0, 16'd0}; player_size = {16'd16, 16'd8};
        run_scan(lat, np);
        chk("wide_dir", cap_dir[0], 4'b0010);
        chk("disabled_dir", cap_dir[1], 4'b0000);
        chk("removed_dir", cap_dir[2], 4'b0000);
        chk("touch_dir", cap_dir[3], 4'b0000);
        chk("wide_pulses", np, 4);
`ifdef HIT_COUNT_EN
        for (int i = 0; i < 3; i++) begin
            tbl_c[i] = {16'd4, 16'd4}; tbl_s[i] = {16'd8, 16'd8}; tbl_e[i] = 1;
        end
        tbl_e[3] = 0;
        player_coord = 0; player_size = {16'd8, 16'd8};
        run_scan(lat, np);
        chk("hit_count3", hit_count, 3);
`endif
        // Reset during a scan: outputs clear, no done follows.
        player_coord = 0; player_size = {16'd40, 16'd40};
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", coll_valid, 0);
        chk("midrst_dir", coll_dir, 0);
        np = 0;
        repeat (20) begin
            @(negedge clk);
            np += done + coll_valid;
        end
        chk("midrst_quiet", np, 0);
        // Randomized scans with spurious start pulses and a moving player input.
        for (int s = 0; s < 60; s++) begin
            for (int i = 0; i < N; i++) begin
                tbl_c[i] = rnd_coord(); tbl_s[i] = rnd_size(); tbl_e[i] = $urandom_range(0, 3) != 0;
            end
            player_coord = rnd_coord();
            player_size = $urandom_range(0, 9) == 0 ? 32'd0 : rnd_size();
            start = 1;
            @(negedge clk);
            for (int k = 0; k < 3 * N + 10 && ph != -1; k++) begin
                start = $urandom_range(0, 1);
                player_coord = $urandom;
                @(negedge clk);
            end
            start = 0;
            if (ph != -1) chk("rand_scan_end", ph, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
